// File: rtl/adc_source_switch_pkg.sv
// Shared types and defaults for the ADC source switch: sample width, mode encodings, frame geometry.
package adc_source_switch_pkg;

  localparam int unsigned ADC_WIDTH    = 14;
  localparam int unsigned CH_NUM_DEF   = 2;
  localparam int unsigned LINE_LEN_DEF = 384;
  localparam int unsigned LINE_NUM_DEF = 288;

  typedef enum logic [1:0] {
    MODE_BOL   = 2'd0,
    MODE_EXT   = 2'd1,
    MODE_RAMP  = 2'd2,
    MODE_CONST = 2'd3
  } mode_e;

  typedef struct packed {
    logic  valid;
    logic  fs;
    logic  frame_err;
    logic  mode_pend;
    mode_e mode_act;
  } status_t;

endpackage

// File: rtl/adc_source_switch_if.sv
// Pixel source bus: capture-side inputs and the selected, registered stream towards the frame buffer.
interface adc_source_switch_if #(
  parameter int unsigned CH_NUM = 2,
  parameter int unsigned DATA_W = 14
);
  logic [CH_NUM*DATA_W-1:0] bol_data;
  logic                     bol_valid;
  logic                     frame_start;
  logic [CH_NUM*DATA_W-1:0] test_data;
  logic [DATA_W-1:0]        const_val;
  logic [1:0]               mode_req;
  logic [CH_NUM*DATA_W-1:0] adc_out;
  logic                     adc_valid;
  logic                     adc_fs;
  logic [1:0]               mode_act;
  logic                     mode_pend;
  logic                     frame_err;

  modport master (
    output bol_data, bol_valid, frame_start, test_data, const_val, mode_req,
    input  adc_out, adc_valid, adc_fs, mode_act, mode_pend, frame_err
  );

  modport slave (
    input  bol_data, bol_valid, frame_start, test_data, const_val, mode_req,
    output adc_out, adc_valid, adc_fs, mode_act, mode_pend, frame_err
  );
endinterface

// File: rtl/adc_pattern_gen.sv
// Column/row position tracker plus ramp and constant pattern generation for every channel.
module adc_pattern_gen #(
  parameter int unsigned CH_NUM   = 2,
  parameter int unsigned DATA_W   = 14,
  parameter int unsigned LINE_LEN = 384,
  parameter int unsigned LINE_NUM = 288
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_beat,
  input  logic                     i_sof,
  input  logic [DATA_W-1:0]        i_const_val,
  output logic [CH_NUM*DATA_W-1:0] o_ramp_c,
  output logic [CH_NUM*DATA_W-1:0] o_const_c
);

  localparam int unsigned COL_W = $clog2(LINE_LEN);
  localparam int unsigned ROW_W = $clog2(LINE_NUM);

  logic [COL_W-1:0] r_col, w_col, w_col_nxt;
  logic [ROW_W-1:0] r_row, w_row, w_row_nxt;

  // Counters hold the position of the next beat; an SOF beat is forced to (0,0).
  always_comb begin
    w_col     = i_sof ? '0 : r_col;
    w_row     = i_sof ? '0 : r_row;
    w_col_nxt = w_col + COL_W'(1);
    w_row_nxt = w_row;
    if (w_col == COL_W'(LINE_LEN - 1)) begin
      w_col_nxt = '0;
      if (w_row != ROW_W'(LINE_NUM - 1)) begin
        w_row_nxt = w_row + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_beat) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

  always_comb begin
    o_ramp_c = '0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      o_ramp_c[c*DATA_W +: DATA_W] = DATA_W'(w_col) + DATA_W'(w_row) + DATA_W'(c);
    end
  end

  assign o_const_c = {CH_NUM{i_const_val}};

endmodule

// File: rtl/adc_source_switch.sv
// Per-frame pixel source selector: mode register, channel mux, output register and frame-length check.
module adc_source_switch
  import adc_source_switch_pkg::*;
#(
  parameter int unsigned CH_NUM   = CH_NUM_DEF,
  parameter int unsigned DATA_W   = ADC_WIDTH,
  parameter int unsigned LINE_LEN = LINE_LEN_DEF,
  parameter int unsigned LINE_NUM = LINE_NUM_DEF
) (
  input logic                clk,
  input logic                rst_n,
  adc_source_switch_if.slave io_bus
);

  localparam int unsigned BUS_W       = CH_NUM * DATA_W;
  localparam int unsigned FRAME_BEATS = LINE_LEN * LINE_NUM;
  localparam int unsigned CNT_W       = $clog2(FRAME_BEATS + 1);

  logic             w_beat;
  logic             w_sof;
  mode_e            w_mode;
  logic             w_len_bad;
  logic [BUS_W-1:0] w_ramp;
  logic [BUS_W-1:0] w_const;
  logic [BUS_W-1:0] w_sel;
  logic [BUS_W-1:0] r_adc_out;
  status_t          r_status;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_first_frame;

  assign w_beat = io_bus.bol_valid;
  assign w_sof  = io_bus.bol_valid & io_bus.frame_start;

  adc_pattern_gen #(
    .CH_NUM  (CH_NUM),
    .DATA_W  (DATA_W),
    .LINE_LEN(LINE_LEN),
    .LINE_NUM(LINE_NUM)
  ) u_pattern_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_beat     (w_beat),
    .i_sof      (w_sof),
    .i_const_val(io_bus.const_val),
    .o_ramp_c   (w_ramp),
    .o_const_c  (w_const)
  );

  // The SOF beat already runs in the newly requested mode.
  always_comb begin
    w_mode    = w_sof ? mode_e'(io_bus.mode_req) : r_status.mode_act;
    w_len_bad = ~r_first_frame && (r_beat_cnt != CNT_W'(FRAME_BEATS));
    w_sel     = io_bus.bol_data;
    case (w_mode)
      MODE_BOL:   w_sel = io_bus.bol_data;
      MODE_EXT:   w_sel = io_bus.test_data;
      MODE_RAMP:  w_sel = w_ramp;
      MODE_CONST: w_sel = w_const;
      default:    w_sel = io_bus.bol_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adc_out     <= '0;
      r_status      <= '0;
      r_beat_cnt    <= '0;
      r_first_frame <= 1'b1;
    end else begin
      r_status.valid     <= w_beat;
      r_status.fs        <= w_sof;
      r_status.frame_err <= w_sof & w_len_bad;
      r_status.mode_pend <= (mode_e'(io_bus.mode_req) != w_mode);
      r_status.mode_act  <= w_mode;
      if (w_beat) begin
        r_adc_out <= w_sel;
      end
      // The SOF beat is the first beat of the new frame.
      if (w_sof) begin
        r_beat_cnt    <= CNT_W'(1);
        r_first_frame <= 1'b0;
      end else if (w_beat && (r_beat_cnt != '1)) begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
    end
  end

  assign io_bus.adc_out   = r_adc_out;
  assign io_bus.adc_valid = r_status.valid;
  assign io_bus.adc_fs    = r_status.fs;
  assign io_bus.frame_err = r_status.frame_err;
  assign io_bus.mode_pend = r_status.mode_pend;
  assign io_bus.mode_act  = r_status.mode_act;

endmodule

// File: tb/tb_adc_source_switch.sv
// Bench for adc_source_switch: directed vector table, async reset, and randomized frames vs a beat-index model.
module tb_adc_source_switch;

  localparam int unsigned CH = 2;
  localparam int unsigned DW = 14;
  localparam int unsigned LL = 384;
  localparam int unsigned LN = 4;
  localparam int unsigned FB = LL * LN;
  localparam int unsigned BW = CH * DW;
  localparam int unsigned VW = BW + 6;

  logic clk;
  logic rst_n;

  adc_source_switch_if #(.CH_NUM(CH), .DATA_W(DW)) bus ();

  adc_source_switch #(
    .CH_NUM  (CH),
    .DATA_W  (DW),
    .LINE_LEN(LL),
    .LINE_NUM(LN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          bv;
    logic          fs;
    logic [1:0]    req;
    logic [BW-1:0] bol;
    logic [BW-1:0] tst;
    logic [DW-1:0] cv;
    logic [BW-1:0] e_out;
    logic          e_valid;
    logic          e_fs;
    logic          e_err;
    logic          e_pend;
    logic [1:0]    e_act;
  } vec_t;

  vec_t tbl [11];

  int n_checks   = 0;
  int n_pass     = 0;
  int n_err_seen = 0;

  // Reference model state: beats since SOF, applied mode, frame-length bookkeeping.
  logic [1:0]    m_mode;
  int            m_k;
  int            m_cnt;
  bit            m_first;
  bit            m_have;
  int            m_probe;
  logic [VW-1:0] m_exp;
  logic [1:0]    m_req;

  function automatic logic [VW-1:0] dut_vec();
    return {bus.adc_out, bus.adc_valid, bus.adc_fs, bus.frame_err, bus.mode_pend, bus.mode_act};
  endfunction

  task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (out,valid,fs,err,pend,act)", name, got, exp);
  endtask

  task automatic drive(input logic bv, input logic fs, input logic [1:0] req,
                       input logic [BW-1:0] bol, input logic [BW-1:0] tst, input logic [DW-1:0] cv);
    bus.bol_valid   = bv;
    bus.frame_start = fs;
    bus.mode_req    = req;
    bus.bol_data    = bol;
    bus.test_data   = tst;
    bus.const_val   = cv;
  endtask

  task automatic model_reset();
    m_mode  = 2'd0;
    m_k     = 0;
    m_cnt   = 0;
    m_first = 1'b1;
    m_have  = 1'b0;
    m_probe = 0;
  endtask

  // One cycle: check last cycle's prediction, apply new inputs, predict next outputs.
  task automatic step_model(input logic bv, input logic fs, input logic [1:0] req,
                            input logic [BW-1:0] bol, input logic [BW-1:0] tst, input logic [DW-1:0] cv);
    logic          sof;
    logic          err;
    logic [BW-1:0] out;
    int            col;
    int            row;
    @(negedge clk);
    if (m_have) begin
      check("model", dut_vec(), m_exp);
      if (bus.frame_err) n_err_seen++;
      if (m_probe == 1) check("ramp_c5_r3", VW'(bus.adc_out), VW'({14'd9, 14'd8}));
      if (m_probe == 2) check("ramp_c0_r1", VW'(bus.adc_out), VW'({14'd2, 14'd1}));
      if (m_probe == 3) check("ramp_c383_r0", VW'(bus.adc_out), VW'({14'd384, 14'd383}));
    end
    drive(bv, fs, req, bol, tst, cv);
    sof     = bv & fs;
    err     = 1'b0;
    m_probe = 0;
    out     = m_exp[VW-1 -: BW];
    if (sof) begin
      err     = !m_first && (m_cnt != FB);
      m_first = 1'b0;
      m_cnt   = 0;
      m_k     = 0;
      m_mode  = req;
    end
    if (bv) begin
      m_cnt++;
      col = m_k % LL;
      row = m_k / LL;
      if (row > LN - 1) row = LN - 1;
      case (m_mode)
        2'd0: out = bol;
        2'd1: out = tst;
        2'd2: for (int c = 0; c < CH; c++) out[c*DW +: DW] = DW'(col + row + c);
        default: for (int c = 0; c < CH; c++) out[c*DW +: DW] = cv;
      endcase
      if (m_mode == 2'd2 && col == 5 && row == 3) m_probe = 1;
      if (m_mode == 2'd2 && col == 0 && row == 1) m_probe = 2;
      if (m_mode == 2'd2 && col == 383 && row == 0) m_probe = 3;
      m_k++;
    end
    m_exp  = {out, bv, sof, err, (req != m_mode), m_mode};
    m_have = 1'b1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'd0, '0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lens [6];
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'd0, '0, '0, '0);
    m_exp = '0;
    model_reset();

    // bv fs req bol tst cv | out valid fs err pend act
    tbl[0]  = '{1'b1, 1'b0, 2'd0, {14'h0123, 14'h0456}, 28'h0AAAAAA, 14'h0000,
                {14'h0123, 14'h0456}, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{1'b0, 1'b0, 2'd0, 28'h1111111, 28'h0AAAAAA, 14'h0000,
                {14'h0123, 14'h0456}, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[2]  = '{1'b1, 1'b0, 2'd1, 28'h2222222, 28'h3333333, 14'h0000,
                28'h2222222, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[3]  = '{1'b1, 1'b0, 2'd1, 28'h4444444, 28'h5555555, 14'h0000,
                28'h4444444, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[4]  = '{1'b1, 1'b1, 2'd1, 28'h6666666, 28'h7777777, 14'h0000,
                28'h7777777, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1};
    tbl[5]  = '{1'b0, 1'b1, 2'd3, 28'h8888888, 28'h9999999, 14'h3FFF,
                28'h7777777, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
    tbl[6]  = '{1'b1, 1'b1, 2'd3, 28'hAAAAAAA, 28'hBBBBBBB, 14'h3FFF,
                {14'h3FFF, 14'h3FFF}, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3};
    tbl[7]  = '{1'b0, 1'b0, 2'd3, 28'hCCCCCCC, 28'hBBBBBBB, 14'h3FFF,
                {14'h3FFF, 14'h3FFF}, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3};
    tbl[8]  = '{1'b1, 1'b0, 2'd2, 28'hDDDDDDD, 28'hEEEEEEE, 14'h1234,
                {14'h1234, 14'h1234}, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3};
    tbl[9]  = '{1'b1, 1'b1, 2'd2, 28'h0F0F0F0, 28'h0E0E0E0, 14'h1234,
                {14'd1, 14'd0}, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2};
    tbl[10] = '{1'b1, 1'b0, 2'd2, 28'h0D0D0D0, 28'h0C0C0C0, 14'h1234,
                {14'd2, 14'd1}, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2};

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_vec(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("vec%0d", i - 1), dut_vec(),
              {tbl[i-1].e_out, tbl[i-1].e_valid, tbl[i-1].e_fs, tbl[i-1].e_err,
               tbl[i-1].e_pend, tbl[i-1].e_act});
      end
      drive(tbl[i].bv, tbl[i].fs, tbl[i].req, tbl[i].bol, tbl[i].tst, tbl[i].cv);
    end
    @(negedge clk);
    check("vec10", dut_vec(),
          {tbl[10].e_out, tbl[10].e_valid, tbl[10].e_fs, tbl[10].e_err, tbl[10].e_pend, tbl[10].e_act});

    // Async reset in the middle of a ramp frame, away from any clock edge.
    drive(1'b1, 1'b0, 2'd2, 28'h1234567, 28'h7654321, 14'h0001);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_vec(), '0);
    apply_reset();
    model_reset();

    lens = '{FB, FB - 1, FB + 5, FB, FB, FB};
    m_req = 2'd0;
    for (int f = 0; f < 6; f++) begin
      for (int b = 0; b < lens[f]; b++) begin
        while ($urandom_range(3) == 0) begin
          step_model(1'b0, 1'($urandom_range(1)), m_req, BW'($urandom), BW'($urandom), DW'($urandom));
        end
        if (b == 0) m_req = (f == 0) ? 2'd2 : 2'($urandom_range(3));
        else if ($urandom_range(255) == 0) m_req = 2'($urandom_range(3));
        step_model(1'b1, (b == 0), m_req, BW'($urandom), BW'($urandom), DW'($urandom));
      end
    end
    step_model(1'b1, 1'b1, m_req, BW'($urandom), BW'($urandom), DW'($urandom));
    step_model(1'b0, 1'b0, m_req, BW'($urandom), BW'($urandom), DW'($urandom));
    step_model(1'b0, 1'b0, m_req, BW'($urandom), BW'($urandom), DW'($urandom));
    check("err_pulse_count", VW'(n_err_seen), VW'(2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
